shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 83 ++++++++
 tb/tb_shift_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives a single-step shift register through load/shift/capture to do multi-bit shifts.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_fill,
    output logic [WIDTH-1:0] sr_input_val,
    output logic             sr_ctrl0,
    output logic             sr_ctrl1,
    output logic             sr_enable,
    output logic             sr_msb,
    output logic             sr_lsb,
    input  logic [WIDTH-1:0] sr_output_val,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPT, RESP} state_t;
    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    state_t state, state_nx;
    logic [WIDTH-1:0] data_q;
    logic dir_q, fill_q;
    logic [AMT_W-1:0] amt_q, cnt, amt_eff;
    assign amt_eff = req_amt > AMT_MAX ? AMT_MAX : req_amt;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= '0;
            dir_q     <= 1'b0;
            fill_q    <= 1'b0;
            amt_q     <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                data_q <= req_data;
                dir_q  <= req_dir;
                fill_q <= req_fill;
                amt_q  <= amt_eff;
            end
            if (state == LOAD) cnt <= amt_q;
            else if (state == SHIFT) cnt <= cnt - 1'b1;
            if (state == CAPT) begin
                rsp_data  <= sr_output_val;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? LOAD : IDLE;
            LOAD:    state_nx = amt_q != '0 ? SHIFT : CAPT;
            SHIFT:   state_nx = cnt == AMT_W'(1) ? CAPT : SHIFT;
            CAPT:    state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    // Register controls come only from state and latched fields, never from req_*.
    always_comb begin
        req_ready    = reset_n && state == IDLE;
        busy         = state != IDLE;
        sr_enable    = state == LOAD || state == SHIFT || state == CAPT;
        sr_ctrl0     = state == SHIFT;
        sr_ctrl1     = state == SHIFT ? dir_q : state != LOAD;
        sr_input_val = state == LOAD ? data_q : '0;
        sr_msb       = state == SHIFT && dir_q && fill_q;
        sr_lsb       = state == SHIFT && !dir_q && fill_q;
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven bench with a shift-register model and a response scoreboard.
module tb_shift_sequencer;
    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic [2:0] amt;
        logic       fill;
        logic [3:0] exp;
    } vec_t;
    logic clock = 1'b0, reset_n = 1'b0;
    logic req_valid = 1'b0, req_dir = 1'b0, req_fill = 1'b0, rsp_ready = 1'b0;
    logic [3:0] req_data = '0;
    logic [2:0] req_amt = '0;
    logic req_ready, sr_ctrl0, sr_ctrl1, sr_enable, sr_msb, sr_lsb, rsp_valid, busy;
    logic [3:0] sr_input_val, sr_q, rsp_data;
    int n_cmp = 0, n_err = 0;
    logic [3:0] sb[$];
    vec_t vt[10];

    shift_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_dir(req_dir), .req_amt(req_amt), .req_fill(req_fill),
        .sr_input_val(sr_input_val), .sr_ctrl0(sr_ctrl0), .sr_ctrl1(sr_ctrl1),
        .sr_enable(sr_enable), .sr_msb(sr_msb), .sr_lsb(sr_lsb), .sr_output_val(sr_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural model of the 4-bit shift register being sequenced
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sr_q <= '0;
        else if (sr_enable)
            case ({sr_ctrl0, sr_ctrl1})
                2'b00:   sr_q <= sr_input_val;
                2'b10:   sr_q <= {sr_q[2:0], sr_lsb};
                2'b11:   sr_q <= {sr_msb, sr_q[3:1]};
                default: sr_q <= sr_q;
            endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic accept(input vec_t v, input bit push);
        int k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("req_ready_wait", int'(req_ready), 1);
        req_valid = 1'b1;
        req_data  = v.data;
        req_dir   = v.dir;
        req_amt   = v.amt;
        req_fill  = v.fill;
        if (push) sb.push_back(v.exp);
        @(negedge clock);
        req_valid = 1'b0;
        req_data  = 4'($urandom);
        req_dir   = 1'($urandom);
        req_amt   = 3'($urandom);
        req_fill  = 1'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int eff = v.amt > 3'd4 ? 4 : int'(v.amt);
        accept(v, 1'b1);
        chk("load_ctrl", int'({sr_enable, sr_ctrl0, sr_ctrl1}), 3'b100);
        chk("load_data", int'(sr_input_val), int'(v.data));
        chk("load_busy", int'({busy, req_ready}), 2'b10);
        for (int i = 0; i < eff; i++) begin
            @(negedge clock);
            chk("shift_ctrl", int'({sr_enable, sr_ctrl0, sr_ctrl1}), int'({2'b11, v.dir}));
            chk("shift_fill", int'({sr_msb, sr_lsb}), v.dir ? int'({v.fill, 1'b0}) : int'({1'b0, v.fill}));
        end
        @(negedge clock);
        chk("capt_ctrl", int'({sr_enable, sr_ctrl0, sr_ctrl1, rsp_valid}), 4'b1010);
        @(negedge clock);
        chk("rsp_valid", int'(rsp_valid), 1);
        chk("rsp_data", int'(rsp_data), int'(sb.pop_front()));
        chk("rsp_sr_idle", int'(sr_enable), 0);
    endtask

    task automatic finish_rsp(input logic [3:0] exp);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_drop", int'(rsp_valid), 0);
        chk("rsp_keep", int'(rsp_data), int'(exp));
        chk("back_idle", int'({busy, req_ready}), 2'b01);
    endtask

    initial begin
        vec_t v;
        bit seen;
        int k;
        vt[0] = '{4'b1010, 1'b0, 3'd0, 1'b0, 4'b1010};
        vt[1] = '{4'b1010, 1'b0, 3'd1, 1'b0, 4'b0100};
        vt[2] = '{4'b1010, 1'b1, 3'd2, 1'b1, 4'b1110};
        vt[3] = '{4'b1111, 1'b1, 3'd6, 1'b0, 4'b0000};
        vt[4] = '{4'b0011, 1'b0, 3'd2, 1'b1, 4'b1111};
        vt[5] = '{4'b1001, 1'b0, 3'd7, 1'b1, 4'b1111};
        vt[6] = '{4'b0110, 1'b1, 3'd1, 1'b0, 4'b0011};
        vt[7] = '{4'b1000, 1'b1, 3'd3, 1'b1, 4'b1111};
        vt[8] = '{4'b0101, 1'b0, 3'd4, 1'b0, 4'b0000};
        vt[9] = '{4'b0110, 1'b0, 3'd3, 1'b1, 4'b0111};
        #12;
        chk("rst_outputs", int'({rsp_valid, sr_enable, sr_ctrl0, sr_ctrl1, req_ready, busy}), 6'b000100);
        chk("rst_data", int'({rsp_data, sr_input_val, sr_msb, sr_lsb}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_release_ready", int'(req_ready), 1);
        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i]);
            finish_rsp(vt[i].exp);
        end
        // Stalled response with a request already waiting
        v = '{4'b1100, 1'b0, 3'd1, 1'b0, 4'b1000};
        run_vec(v);
        req_valid = 1'b1;
        req_data  = 4'b0011;
        req_dir   = 1'b0;
        req_amt   = 3'd1;
        req_fill  = 1'b0;
        sb.push_back(4'b0110);
        repeat (5) begin
            @(negedge clock);
            chk("stall_hold", int'({rsp_valid, rsp_data, req_ready, sr_enable}), int'({1'b1, 4'b1000, 2'b00}));
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("stall_release", int'({rsp_valid, busy, req_ready}), 3'b001);
        @(negedge clock);
        req_valid = 1'b0;
        chk("pend_accept", int'({busy, sr_enable, sr_ctrl0, sr_ctrl1, sr_input_val}), int'({4'b1100, 4'b0011}));
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("pend_latency", k, 3);
        chk("pend_data", int'(rsp_data), int'(sb.pop_front()));
        finish_rsp(4'b0110);
        // Asynchronous reset in the middle of a shift
        v = '{4'b1111, 1'b1, 3'd4, 1'b0, 4'b0000};
        accept(v, 1'b0);
        @(negedge clock);
        chk("abort_in_shift", int'({sr_enable, sr_ctrl0, sr_ctrl1}), 3'b111);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_outputs", int'({rsp_valid, sr_enable, sr_ctrl0, sr_ctrl1, req_ready, busy}), 6'b000100);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("abort_ready", int'({req_ready, busy}), 2'b10);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            seen |= rsp_valid | sr_enable;
        end
        chk("abort_no_rsp", int'(seen), 0);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
